// File: rtl/zap_dbus_pkg.sv
// Shared types for the ZAP data-bus arbiter: FSM states, latched request and owner ids.
package zap_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } dbus_state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int TIMER_W = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        owner;
  } dbus_req_t;

endpackage

// File: rtl/zap_dbus_arbiter_if.sv
// Requester handshakes plus the Wishbone classic data bus, as seen by the arbiter.
interface zap_dbus_arbiter_if;

  logic        i_p0_req, i_p0_we;
  logic [31:0] i_p0_adr, i_p0_dat;
  logic [3:0]  i_p0_sel;
  logic        o_p0_done, o_p0_err;
  logic [31:0] o_p0_rdat;

  logic        i_p1_req, i_p1_we;
  logic [31:0] i_p1_adr, i_p1_dat;
  logic [3:0]  i_p1_sel;
  logic        o_p1_done, o_p1_err;
  logic [31:0] o_p1_rdat;

  logic        o_data_stall, o_data_mem_fault;

  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] i_wb_dat;

  // master: the arbiter itself
  modport master (
    input  i_p0_req, i_p0_we, i_p0_adr, i_p0_dat, i_p0_sel,
    input  i_p1_req, i_p1_we, i_p1_adr, i_p1_dat, i_p1_sel,
    output o_p0_done, o_p0_err, o_p0_rdat,
    output o_p1_done, o_p1_err, o_p1_rdat,
    output o_data_stall, o_data_mem_fault,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    input  i_wb_ack, i_wb_err, i_wb_dat
  );

  // slave: requesters and the bus slave around the arbiter
  modport slave (
    output i_p0_req, i_p0_we, i_p0_adr, i_p0_dat, i_p0_sel,
    output i_p1_req, i_p1_we, i_p1_adr, i_p1_dat, i_p1_sel,
    input  o_p0_done, o_p0_err, o_p0_rdat,
    input  o_p1_done, o_p1_err, o_p1_rdat,
    input  o_data_stall, o_data_mem_fault,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    output i_wb_ack, i_wb_err, i_wb_dat
  );

endinterface

// File: rtl/zap_dbus_rr_pick.sv
// Two-way round-robin picker; on a tie the requester not granted last wins.
module zap_dbus_rr_pick (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_valid,
  output logic       o_owner
);
  import zap_dbus_pkg::*;

  logic last;

  always_comb begin
    o_owner = P0;
    if (i_req == 2'b11) o_owner = ~last;
    else if (i_req[1])  o_owner = P1;
  end

  assign o_valid = |i_req;

  // Resetting to P1 hands the first tie to the memory stage.
  always_ff @(posedge i_clk) begin
    if (i_reset)       last <= P1;
    else if (i_update) last <= o_owner;
  end

endmodule

// File: rtl/zap_dbus_arbiter.sv
// Data-side bus arbiter: grants p0 (memory stage) or p1 (page walker) one
// Wishbone classic cycle at a time and returns done/err/rdat to the owner.
module zap_dbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear_from_writeback,
  zap_dbus_arbiter_if.master bus
);
  import zap_dbus_pkg::*;

  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  dbus_state_t        state;
  dbus_req_t          cur, win;
  logic [TIMER_W-1:0] timer;
  logic               kill, kill_nxt;
  logic [1:0]         cand;
  logic               pick_vld, pick_owner, grant;
  logic               timeout, term;

  assign cand  = {bus.i_p1_req, bus.i_p0_req & ~i_clear_from_writeback};
  assign grant = (state == IDLE) & pick_vld;

  zap_dbus_rr_pick u_pick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (cand),
    .i_update (grant),
    .o_valid  (pick_vld),
    .o_owner  (pick_owner)
  );

  always_comb begin
    win = '0;
    if (pick_owner == P1) begin
      win.we  = bus.i_p1_we;
      win.adr = bus.i_p1_adr;
      win.dat = bus.i_p1_dat;
      win.sel = bus.i_p1_sel;
      win.owner = P1;
    end else begin
      win.we  = bus.i_p0_we;
      win.adr = bus.i_p0_adr;
      win.dat = bus.i_p0_dat;
      win.sel = bus.i_p0_sel;
      win.owner = P0;
    end
  end

  assign timeout  = (timer == TO_LAST);
  assign term     = bus.i_wb_ack | bus.i_wb_err | timeout;
  // A flush in the terminating cycle still has to kill the p0 completion.
  assign kill_nxt = kill | (i_clear_from_writeback & (cur.owner == P0));

  assign bus.o_wb_we  = cur.we;
  assign bus.o_wb_adr = cur.adr;
  assign bus.o_wb_dat = cur.dat;
  assign bus.o_wb_sel = cur.sel;

  assign bus.o_data_stall     = bus.i_p0_req & ~bus.o_p0_done;
  assign bus.o_data_mem_fault = bus.o_p0_done & bus.o_p0_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cur           <= '0;
      timer         <= '0;
      kill          <= 1'b0;
      bus.o_wb_cyc  <= 1'b0;
      bus.o_wb_stb  <= 1'b0;
      bus.o_p0_done <= 1'b0;
      bus.o_p0_err  <= 1'b0;
      bus.o_p0_rdat <= '0;
      bus.o_p1_done <= 1'b0;
      bus.o_p1_err  <= 1'b0;
      bus.o_p1_rdat <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (pick_vld) begin
            cur          <= win;
            timer        <= '0;
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            state        <= BUS;
          end
        end
        BUS: begin
          kill <= kill_nxt;
          if (term) begin
            bus.o_wb_cyc <= 1'b0;
            bus.o_wb_stb <= 1'b0;
            state        <= DONE;
            if (cur.owner == P0) begin
              bus.o_p0_rdat <= bus.i_wb_dat;
              bus.o_p0_done <= ~kill_nxt;
              bus.o_p0_err  <= ~kill_nxt & (bus.i_wb_err | timeout);
            end else begin
              bus.o_p1_rdat <= bus.i_wb_dat;
              bus.o_p1_done <= 1'b1;
              bus.o_p1_err  <= bus.i_wb_err | timeout;
            end
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // Requests are not sampled here, so a stale req cannot re-grant.
          bus.o_p0_done <= 1'b0;
          bus.o_p0_err  <= 1'b0;
          bus.o_p1_done <= 1'b0;
          bus.o_p1_err  <= 1'b0;
          kill          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
